// File: rtl/bf_row_ctrl.sv
// bf_row_ctrl: request/clear sequencer for one 4096x1 bloom-filter row
// held in a true dual-port RAM with RD_LAT clocks of read latency.
//
// Ports
//   clock, reset      single clock; asynchronous active-high reset
//   req_valid/ready   request handshake (accepted when both are high)
//   req_op            0 = query, 1 = insert (set bit)
//   req_idx, req_tag  bit index and query tag
//   rsp_valid/hit/tag one-cycle query response, acceptance order
//   clr_start         ask for the whole row to be zeroed
//   clr_busy/done     clear pending/running, completion pulse
//   ram_*             registered RAM port A/B controls, ram_q_a read data

module bf_row_ctrl #(
  parameter int RD_LAT = 2,
  parameter int TAG_W  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [11:0]      req_idx,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [TAG_W-1:0] rsp_tag,
  input  logic             clr_start,
  output logic             clr_busy,
  output logic             clr_done,
  output logic [11:0]      ram_address_a,
  output logic [11:0]      ram_address_b,
  output logic             ram_data_a,
  output logic             ram_data_b,
  output logic             ram_wren_a,
  output logic             ram_wren_b,
  input  logic             ram_q_a,
  input  logic             ram_q_b
);

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [RD_LAT:0]  r_pv;
  logic [TAG_W-1:0] r_pt [RD_LAT+1];

  // bit 11 set means the 2048-pair sweep has been fully issued
  logic [11:0] r_n;

  logic w_accept;
  logic w_query;
  logic w_pipe_empty;
  logic w_sweep_on;
  logic w_sweep_end;
  logic w_unused_q_b;

  assign w_accept     = req_valid && req_ready;
  assign w_query      = w_accept && !req_op;
  assign w_pipe_empty = (r_pv == '0);
  assign w_sweep_on   = (r_state == CLEAR) && !r_n[11];
  assign w_sweep_end  = (r_state == CLEAR) && r_n[11];
  assign w_unused_q_b = ram_q_b;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    clr_busy    = 1'b1;
    unique case (r_state)
      SERVE: begin
        clr_busy  = 1'b0;
        req_ready = !clr_start;
        if (clr_start) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_pipe_empty) begin
          w_state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        if (r_n[11]) begin
          w_state_nxt = SERVE;
        end
      end
      default: begin
        w_state_nxt = CLEAR;
      end
    endcase
  end

  // Query tracking: r_pv[i] marks a query whose read address was
  // presented i cycles ago; r_pv[RD_LAT] lines up with ram_q_a.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pv      <= '0;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_tag   <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        r_pt[i] <= '0;
      end
    end else begin
      r_pv    <= {r_pv[RD_LAT-1:0], w_query};
      r_pt[0] <= req_tag;
      for (int i = 1; i <= RD_LAT; i++) begin
        r_pt[i] <= r_pt[i-1];
      end
      rsp_valid <= r_pv[RD_LAT];
      if (r_pv[RD_LAT]) begin
        rsp_hit <= ram_q_a;
        rsp_tag <= r_pt[RD_LAT];
      end
    end
  end

  // RAM port drive. Port A address is held when idle so the RAM
  // does not see needless address toggles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ram_address_a <= '0;
      ram_address_b <= '0;
      ram_data_a    <= 1'b0;
      ram_data_b    <= 1'b0;
      ram_wren_a    <= 1'b0;
      ram_wren_b    <= 1'b0;
      r_n           <= '0;
      clr_done      <= 1'b0;
    end else begin
      ram_wren_a    <= 1'b0;
      ram_data_a    <= 1'b0;
      ram_wren_b    <= 1'b0;
      ram_data_b    <= 1'b0;
      ram_address_b <= '0;
      clr_done      <= w_sweep_end;
      if (w_accept) begin
        ram_address_a <= req_idx;
        ram_wren_a    <= req_op;
        ram_data_a    <= req_op;
      end
      if (w_sweep_on) begin
        ram_address_a <= {r_n[10:0], 1'b0};
        ram_address_b <= {r_n[10:0], 1'b1};
        ram_wren_a    <= 1'b1;
        ram_wren_b    <= 1'b1;
        r_n           <= r_n + 12'd1;
      end
      if (w_sweep_end) begin
        r_n <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bf_row_ctrl.sv
// tb_bf_row_ctrl: directed + randomized bench for bf_row_ctrl
// against a cycle-scheduled behavioural model and a RAM model.

module tb_bf_row_ctrl;

  localparam int RD_LAT = 2;
  localparam int TAG_W  = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid, req_ready, req_op;
  logic [11:0]      req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid, rsp_hit;
  logic [TAG_W-1:0] rsp_tag;
  logic             clr_start, clr_busy, clr_done;
  logic [11:0]      ram_address_a, ram_address_b;
  logic             ram_data_a, ram_data_b;
  logic             ram_wren_a, ram_wren_b;
  logic             ram_q_a, ram_q_b;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clock = ~clock;

  bf_row_ctrl #(.RD_LAT(RD_LAT), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_idx(req_idx), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_tag(rsp_tag),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .ram_address_a(ram_address_a), .ram_address_b(ram_address_b),
    .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
    .ram_wren_a(ram_wren_a), .ram_wren_b(ram_wren_b),
    .ram_q_a(ram_q_a), .ram_q_b(ram_q_b)
  );

  // RAM: read-before-write, RD_LAT clocks from address to q
  bit              mem [4096];
  logic [RD_LAT-1:0] qd = '0;
  assign ram_q_a = qd[RD_LAT-1];
  assign ram_q_b = 1'b0;

  always @(posedge clock) begin
    qd <= (qd << 1) | RD_LAT'(mem[ram_address_a]);
    if (ram_wren_a) mem[ram_address_a] <= ram_data_a;
    if (ram_wren_b) mem[ram_address_b] <= ram_data_b;
  end

  initial begin
    foreach (mem[j]) mem[j] = 1'($urandom);
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: row contents as a bit array, responses as a
  // queue of (due cycle, hit, tag), clear as a scheduled sweep window.
  typedef struct {
    int               due;
    bit               hit;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  rsp_t             rq[$];
  bit               bm [4096];
  int               cyc      = 0;
  int               w0       = 1;
  int               last_due = 0;
  bit               m_serve  = 1'b0;
  bit               e_wa = 0, e_wb = 0, e_da = 0, e_done = 0;
  bit               e_rv = 0, e_hit = 0;
  logic [TAG_W-1:0] e_tag = '0;
  logic [11:0]      e_aa = '0, e_ab = '0;

  always @(posedge clock) begin
    int k;
    cyc++;
    e_wa   = 0;
    e_wb   = 0;
    e_da   = 0;
    e_ab   = '0;
    e_done = 0;
    e_rv   = 0;
    if (reset) begin
      m_serve  = 0;
      rq.delete();
      last_due = 0;
      w0       = cyc + 1;
      e_aa     = '0;
    end else begin
      if (m_serve) begin
        if (clr_start) begin
          m_serve = 0;
          w0 = ((cyc > last_due) ? cyc : last_due) + 2;
        end else if (req_valid) begin
          e_aa = req_idx;
          e_wa = req_op;
          e_da = req_op;
          if (req_op) begin
            bm[req_idx] = 1'b1;
          end else begin
            rq.push_back('{due: cyc + RD_LAT + 1,
                           hit: bm[req_idx], tag: req_tag});
            last_due = cyc + RD_LAT + 1;
          end
        end
      end
      if (!m_serve && cyc >= w0 && cyc < w0 + 2048) begin
        k = cyc - w0;
        if (k == 0) foreach (bm[j]) bm[j] = 1'b0;
        e_wa = 1;
        e_wb = 1;
        e_aa = 12'(2 * k);
        e_ab = 12'(2 * k + 1);
      end else if (!m_serve && cyc == w0 + 2048) begin
        e_done  = 1;
        m_serve = 1;
      end
      if (rq.size() > 0 && rq[0].due == cyc) begin
        e_rv  = 1;
        e_hit = rq[0].hit;
        e_tag = rq[0].tag;
        void'(rq.pop_front());
      end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      chk("rst_busy", clr_busy, 1);
      chk("rst_out", {rsp_valid, rsp_hit, rsp_tag, clr_done, req_ready,
                      ram_wren_a, ram_wren_b, ram_data_a, ram_data_b,
                      ram_address_a, ram_address_b}, 0);
    end else begin
      chk("ctrl", {req_ready, clr_busy, clr_done},
          {m_serve && !clr_start, !m_serve, e_done});
      chk("rsp_valid", rsp_valid, e_rv);
      if (e_rv) chk("rsp", {rsp_hit, rsp_tag}, {e_hit, e_tag});
      chk("porta", {ram_wren_a, ram_address_a, ram_wren_a & ram_data_a},
          {e_wa, e_aa, e_da});
      chk("portb", {ram_wren_b, ram_address_b, ram_data_b},
          {e_wb, e_ab, 1'b0});
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit v, input bit op, input logic [11:0] idx,
                       input logic [TAG_W-1:0] tag);
    req_valid = v;
    req_op    = op;
    req_idx   = idx;
    req_tag   = tag;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int i = 0; i < 2300 && !seen; i++) begin
      step();
      if (clr_done) seen = 1;
    end
    chk(nm, seen, 1);
  endtask

  task automatic query_chk(input string nm, input logic [11:0] idx,
                           input logic [TAG_W-1:0] tag, input bit hit);
    drive(1, 0, idx, tag);
    step();
    drive(0, 0, 0, 0);
    step();
    step();
    step();
    chk(nm, {rsp_valid, rsp_hit, rsp_tag}, {1'b1, hit, tag});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cnt;
    bit found;
    drive(0, 0, 0, 0);
    clr_start = 0;
    #1 reset = 1;
    step();
    step();
    #2 reset = 0;

    // power-up clear
    step();
    chk("clr_first", {ram_wren_a, ram_wren_b, ram_address_a, ram_address_b},
        {1'b1, 1'b1, 12'd0, 12'd1});
    k = 1;
    found = 0;
    while (k < 2300 && !found) begin
      step();
      k++;
      if (clr_done) found = 1;
    end
    chk("clr_done_cycle", k, 2049);
    chk("ready_after_clr", req_ready, 1);
    step();
    chk("clr_done_once", clr_done, 0);

    // insert then back-to-back queries
    drive(1, 1, 12'h123, 0);
    step();
    drive(1, 0, 12'h123, 8'h5A);
    step();
    drive(1, 0, 12'h124, 8'h5B);
    step();
    drive(0, 0, 0, 0);
    step();
    step();
    chk("q123", {rsp_valid, rsp_hit, rsp_tag}, {1'b1, 1'b1, 8'h5A});
    step();
    chk("q124", {rsp_valid, rsp_hit, rsp_tag}, {1'b1, 1'b0, 8'h5B});
    step();

    // boundary indices
    drive(1, 1, 12'hFFF, 0);
    step();
    query_chk("qfff", 12'hFFF, 8'h01, 1);
    query_chk("q000", 12'h000, 8'h02, 0);
    step();

    // 8 streamed queries
    for (int j = 0; j < 12; j++) begin
      if (j >= 4)
        chk("stream", {rsp_valid, rsp_tag}, {1'b1, 8'(j - 4)});
      if (j < 8) drive(1, 0, 12'h200 + 12'(j), 8'(j));
      else       drive(0, 0, 0, 0);
      step();
    end
    chk("stream_end", rsp_valid, 0);

    // clear with queries in flight
    for (int j = 0; j < 3; j++) begin
      drive(1, 0, 12'h123, 8'(10 + j));
      step();
    end
    drive(1, 0, 12'h456, 8'd13);
    clr_start = 1;
    #1;
    chk("clr_blocks_req", req_ready, 0);
    step();
    clr_start = 0;
    drive(0, 0, 0, 0);
    cnt = 0;
    for (int j = 0; j < 8; j++) begin
      if (rsp_valid) cnt++;
      step();
    end
    chk("drain_rsp", cnt, 3);
    chk("drain_busy", clr_busy, 1);
    wait_done("clr2_done");
    query_chk("q123_cleared", 12'h123, 8'd14, 0);

    // reset in the middle of a clear
    clr_start = 1;
    step();
    clr_start = 0;
    found = 0;
    for (int i = 0; i < 2300 && !found; i++) begin
      if (ram_wren_a && ram_address_a == 12'd2000) found = 1;
      else step();
    end
    chk("reach_n1000", found, 1);
    #2 reset = 1;
    #1;
    chk("async_rst", {rsp_valid, rsp_hit, rsp_tag, clr_done, clr_busy,
                      req_ready, ram_wren_a, ram_wren_b, ram_address_a},
        {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0});
    step();
    step();
    #2 reset = 0;
    step();
    chk("clr_restart", {ram_wren_a, ram_wren_b, ram_address_a, ram_address_b},
        {1'b1, 1'b1, 12'd0, 12'd1});
    wait_done("clr3_done");

    // random traffic checked by the model every cycle
    for (int i = 0; i < 5000; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
            12'($urandom_range(0, 63)), 8'($urandom));
      clr_start = ($urandom_range(0, 299) == 0) || (i == 3000);
      if (i == 1200) begin
        #2 reset = 1;
        @(posedge clock);
        #3 reset = 0;
      end
      step();
    end
    drive(0, 0, 0, 0);
    clr_start = 0;
    for (int i = 0; i < 10; i++) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/bf_row_ctrl.md
BF_ROW_CTRL -- requirements
Module: bf_row_ctrl

Interface
REQ-001 SHALL have parameter RD_LAT, default 2: the RAM read latency in clocks, from the address-registered cycle to valid q.
REQ-002 SHALL have parameter TAG_W, default 8: the width of the query tag.
REQ-003 clock  input  1  the single clock for all logic.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  request accepted when req_valid && req_ready at a rising edge.
REQ-007 req_op  input  1  0 = query, 1 = insert (set bit).
REQ-008 req_idx  input  12  bit index into the 4096x1 row.
REQ-009 req_tag  input  TAG_W  query tag, echoed on the response.
REQ-010 rsp_valid  output  1  query response, one cycle, no backpressure.
REQ-011 rsp_hit  output  1  stored bit value for the query.
REQ-012 rsp_tag  output  TAG_W  tag of the answered query.
REQ-013 clr_start  input  1  request to zero the whole row.
REQ-014 clr_busy  output  1  clear pending or in progress.
REQ-015 clr_done  output  1  one-cycle pulse when a clear completes.
REQ-016 ram_address_a, ram_address_b  output  12  RAM port addresses.
REQ-017 ram_data_a, ram_data_b  output  1  RAM write data.
REQ-018 ram_wren_a, ram_wren_b  output  1  RAM write enables.
REQ-019 ram_q_a, ram_q_b  input  1  RAM read data (ram_q_b unused).

Function
REQ-020 SHALL implement FSM states SERVE, DRAIN, CLEAR.
REQ-021 SHALL drive req_ready = (state==SERVE) && !clr_start.
REQ-022 SHALL register all ram_* outputs; a request accepted at edge T appears on port A during cycle T+1.
REQ-023 Query: SHALL drive ram_address_a=req_idx and ram_wren_a=0 in cycle T+1, capture ram_q_a in cycle T+1+RD_LAT, and assert rsp_valid/rsp_hit/rsp_tag (registered) in cycle T+2+RD_LAT (4 cycles with the default).
REQ-024 Insert: SHALL drive ram_address_a=req_idx, ram_data_a=1, ram_wren_a=1 for exactly cycle T+1; an insert produces no response.
REQ-025 SHALL sustain one request per cycle and return responses in acceptance order, via a (RD_LAT+1)-deep valid/tag shift pipeline.
REQ-026 A query accepted after an insert to the same index SHALL return hit=1, because the insert's write cycle precedes the query's read cycle.
REQ-027 When the pipeline is idle, SHALL drive ram_wren_a=0 and hold ram_address_a at its last value.
REQ-028 Outside CLEAR, SHALL drive ram_wren_b=0, ram_address_b=0, ram_data_b=0.
REQ-029 SERVE + clr_start: SHALL go to DRAIN; a req_valid in the same cycle SHALL NOT be accepted.
REQ-030 DRAIN: SHALL accept no requests, complete every in-flight query response, and enter CLEAR the cycle after the pipeline is empty.
REQ-031 CLEAR: an 11-bit counter n = 0..2047 SHALL drive ram_address_a={n,0}, ram_address_b={n,1}, both wren=1, both data=0, one pair per cycle, for 2048 write cycles.
REQ-032 After the n=2047 write cycle: SHALL pulse clr_done for one cycle, deassert clr_busy in the same cycle, and return to SERVE.
REQ-033 clr_busy SHALL be 1 in DRAIN and CLEAR and 0 in SERVE; clr_start SHALL be ignored outside SERVE.

Reset
REQ-034 Asynchronous reset SHALL immediately force: state=CLEAR, n=0, pipeline empty, rsp_valid=0, rsp_hit=0, rsp_tag=0, clr_done=0, clr_busy=1, req_ready=0, all ram_* outputs 0.
REQ-035 After reset release, the first clear write pair SHALL occur in the first clock cycle; the automatic initial clear SHALL complete before any request is accepted.
REQ-036 Reset during CLEAR or with queries in flight SHALL discard all in-flight state and restart the clear from n=0.

Verification
REQ-037 Release reset -> 2048 cycles of (0,1),(2,3)...(4094,4095) writes with data 0; clr_done pulses once; req_ready=1 the next cycle.
REQ-038 Insert 0x123, then query 0x123 tag 0x5A, then query 0x124 tag 0x5B, back to back -> hit=1/tag 0x5A 4 cycles after its acceptance, then hit=0/tag 0x5B the following cycle.
REQ-039 8 consecutive queries with tags 0..7 -> 8 responses on consecutive cycles, tags 0..7 in order.
REQ-040 clr_start with 3 queries in flight and req_valid high -> request not accepted; 3 responses delivered; clear runs; a later query of 0x123 returns hit=0.
REQ-041 Assert reset at clear count n=1000 -> all outputs take reset values asynchronously; after release the clear restarts at address pair (0,1).
REQ-042 Insert to 0xFFF and query 0x000 -> boundary indices map correctly: query 0xFFF hit=1, query 0x000 hit=0.
